// File: rtl/alu_result_display.sv
// Output stage for the 3-bit sign-magnitude add/sub unit: captures a result over valid/ready,
// presents it as sign-magnitude and two's complement, and scans it onto a 2-digit 7-seg display.
module alu_result_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] r_in,
  input  logic       r_valid,
  output logic       r_ready,
  output logic [3:0] sm_out,
  output logic [3:0] twos_out,
  output logic       neg_out,
  output logic       shown,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  logic [3:0]    held_q, held_d;
  logic          shown_q, shown_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic          sel_q, sel_d;
  logic          capture;

  assign r_ready = (hold_q == '0);
  assign capture = r_valid && r_ready;

  always_comb begin
    held_d    = held_q;
    shown_d   = shown_q;
    hold_d    = hold_q;
    refresh_d = refresh_q;
    sel_d     = sel_q;
    if (capture) begin
      // Negative zero is folded to +0 so every consumer sees one encoding of zero.
      held_d  = (r_in == 4'b1000) ? 4'b0000 : r_in;
      shown_d = 1'b1;
      hold_d  = HW'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      sel_d     = ~sel_q;
    end else begin
      refresh_d = refresh_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q    <= 4'b0000;
      shown_q   <= 1'b0;
      hold_q    <= '0;
      refresh_q <= '0;
      sel_q     <= 1'b0;
    end else begin
      held_q    <= held_d;
      shown_q   <= shown_d;
      hold_q    <= hold_d;
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
    end
  end

  assign sm_out   = held_q;
  assign neg_out  = held_q[3];
  assign shown    = shown_q;
  assign twos_out = held_q[3] ? (~{1'b0, held_q[2:0]} + 4'd1) : {1'b0, held_q[2:0]};
  assign an       = sel_q ? 2'b01 : 2'b10;

  always_comb begin
    seg = 7'b1111111;
    if (shown_q) begin
      if (sel_q) begin
        seg = held_q[3] ? 7'b0111111 : 7'b1111111;
      end else begin
        case (held_q[2:0])
          3'd0:    seg = 7'b1000000;
          3'd1:    seg = 7'b1111001;
          3'd2:    seg = 7'b0100100;
          3'd3:    seg = 7'b0110000;
          3'd4:    seg = 7'b0011001;
          3'd5:    seg = 7'b0010010;
          3'd6:    seg = 7'b0000010;
          default: seg = 7'b1111000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Randomised self-checking bench for alu_result_display against a cycle-count based reference.
module tb_alu_result_display;

  localparam int RD = 4;
  localparam int HD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] r_in = 4'b0000;
  logic       r_valid = 1'b0;
  logic       r_ready;
  logic [3:0] sm_out, twos_out;
  logic       neg_out, shown;
  logic [6:0] seg;
  logic [1:0] an;

  int checks = 0;
  int failures = 0;
  int edge_cnt;
  int cap_edge = 0;
  bit any_cap = 1'b0;
  logic [3:0] exp_held = 4'b0000;

  alu_result_display #(.REFRESH_DIV(RD), .HOLD_CYCLES(HD)) dut (
    .clk(clk), .rst_n(rst_n), .r_in(r_in), .r_valid(r_valid), .r_ready(r_ready),
    .sm_out(sm_out), .twos_out(twos_out), .neg_out(neg_out), .shown(shown),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Edges since reset release; refresh phase and hold window are derived from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] canon(input logic [3:0] v);
    return (v == 4'b1000) ? 4'b0000 : v;
  endfunction

  function automatic logic [3:0] ref_twos(input logic [3:0] v);
    int val;
    val = v[3] ? -int'(v[2:0]) : int'(v[2:0]);
    return val[3:0];
  endfunction

  function automatic logic [6:0] glyph(input logic [2:0] m);
    case (m)
      3'd0: return 7'b1000000;
      3'd1: return 7'b1111001;
      3'd2: return 7'b0100100;
      3'd3: return 7'b0110000;
      3'd4: return 7'b0011001;
      3'd5: return 7'b0010010;
      3'd6: return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  function automatic logic exp_ready();
    return !any_cap || ((edge_cnt - cap_edge) >= HD);
  endfunction

  function automatic logic [1:0] exp_an();
    return (((edge_cnt / RD) % 2) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg();
    if (!any_cap) return 7'b1111111;
    if (exp_an() == 2'b10) return glyph(exp_held[2:0]);
    return exp_held[3] ? 7'b0111111 : 7'b1111111;
  endfunction

  // Presents v until accepted; returns at the falling edge after the capture edge.
  task automatic send(input logic [3:0] v);
    bit done = 1'b0;
    r_in = v;
    r_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (r_ready) begin
        @(negedge clk);
        r_valid = 1'b0;
        any_cap = 1'b1;
        cap_edge = edge_cnt;
        exp_held = canon(v);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: r_ready=%b, required acceptance of %b", r_ready, v);
      r_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({r_ready, shown, sm_out, twos_out, neg_out, an, seg} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'b1111111}) begin
      failures++;
      $display("FAIL reset_state: ready=%b shown=%b sm=%b twos=%b neg=%b an=%b seg=%b, required 1 0 0000 0000 0 10 1111111",
               r_ready, shown, sm_out, twos_out, neg_out, an, seg);
    end
    any_cap = 1'b0;
    exp_held = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released at %0t", $time);
  endtask

  task automatic test_refresh();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({r_ready, shown, seg, an} !== {1'b1, 1'b0, 7'b1111111, exp_an()}) begin
        failures++;
        $display("FAIL refresh_idle[%0d]: ready=%b shown=%b seg=%b an=%b, required 1 0 1111111 %b",
                 i, r_ready, shown, seg, an, exp_an());
      end
      @(negedge clk);
    end
    $display("refresh idle scan: 20 cycles checked");
  endtask

  task automatic test_neg6();
    send(4'b1110);
    checks++;
    if ({sm_out, twos_out, neg_out} !== {4'b1110, 4'b1010, 1'b1}) begin
      failures++;
      $display("FAIL neg6_values: sm=%b twos=%b neg=%b, required 1110 1010 1", sm_out, twos_out, neg_out);
    end
    for (int i = 0; i < 2 * RD; i++) begin
      checks++;
      if (an !== exp_an() || seg !== ((exp_an() == 2'b10) ? 7'b0000010 : 7'b0111111)) begin
        failures++;
        $display("FAIL neg6_display[%0d]: an=%b seg=%b, required an=%b seg=%b", i, an, seg, exp_an(),
                 (exp_an() == 2'b10) ? 7'b0000010 : 7'b0111111);
      end
      @(negedge clk);
    end
    $display("captured -6: sm=%b twos=%b", sm_out, twos_out);
  endtask

  task automatic test_negzero();
    send(4'b1000);
    checks++;
    if ({sm_out, twos_out, neg_out} !== {4'b0000, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL negzero_values: sm=%b twos=%b neg=%b, required 0000 0000 0", sm_out, twos_out, neg_out);
    end
    for (int i = 0; i < 2 * RD; i++) begin
      checks++;
      if (an !== exp_an() || seg !== ((exp_an() == 2'b10) ? 7'b1000000 : 7'b1111111)) begin
        failures++;
        $display("FAIL negzero_display[%0d]: an=%b seg=%b, required an=%b seg=%b", i, an, seg, exp_an(),
                 (exp_an() == 2'b10) ? 7'b1000000 : 7'b1111111);
      end
      @(negedge clk);
    end
    $display("captured -0: sm=%b twos=%b", sm_out, twos_out);
  endtask

  task automatic test_hold();
    int low = 0;
    int first_cap;
    while (!r_ready) @(negedge clk);
    send(4'b0101);
    first_cap = cap_edge;
    r_in = 4'b0010;
    r_valid = 1'b1;
    while (!r_ready && low < 50) begin
      checks++;
      if (sm_out !== 4'b0101) begin
        failures++;
        $display("FAIL hold_keeps_value: sm=%b, required 0101", sm_out);
      end
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != HD) begin
      failures++;
      $display("FAIL hold_length: r_ready low for %0d cycles, required %0d", low, HD);
    end
    send(4'b0010);
    checks++;
    if (twos_out !== 4'b0010 || (cap_edge - first_cap) != HD + 1) begin
      failures++;
      $display("FAIL hold_next_capture: twos=%b after %0d edges, required 0010 after %0d edges",
               twos_out, cap_edge - first_cap, HD + 1);
    end
    $display("hold: ready low %0d cycles, then captured twos=%b", low, twos_out);
  endtask

  task automatic test_async_reset();
    while (!r_ready) @(negedge clk);
    send(4'b1011);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_ready, shown, sm_out, twos_out, neg_out, an, seg} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 2'b10, 7'b1111111}) begin
      failures++;
      $display("FAIL async_reset: ready=%b shown=%b sm=%b twos=%b neg=%b an=%b seg=%b, required 1 0 0000 0000 0 10 1111111",
               r_ready, shown, sm_out, twos_out, neg_out, an, seg);
    end
    any_cap = 1'b0;
    exp_held = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (r_ready !== 1'b1 || seg !== 7'b1111111 || an !== exp_an()) begin
      failures++;
      $display("FAIL async_release: ready=%b seg=%b an=%b, required 1 1111111 %b", r_ready, seg, an, exp_an());
    end
    $display("async reset during hold of -3 cleared outputs");
  endtask

  task automatic test_sweep();
    logic [3:0] order [16];
    logic [3:0] tmp;
    int j;
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 16; i++) begin
      send(order[i]);
      checks++;
      if (twos_out !== ref_twos(order[i]) || sm_out !== canon(order[i]) || neg_out !== canon(order[i]) >> 3) begin
        failures++;
        $display("FAIL sweep_value r_in=%b: sm=%b twos=%b neg=%b, required %b %b %b", order[i], sm_out,
                 twos_out, neg_out, canon(order[i]), ref_twos(order[i]), canon(order[i][3]));
      end
      for (int k = 0; k < RD + 1; k++) begin
        checks++;
        if (r_ready !== exp_ready() || an !== exp_an() || seg !== exp_seg()) begin
          failures++;
          $display("FAIL sweep_display r_in=%b: ready=%b an=%b seg=%b, required %b %b %b", order[i],
                   r_ready, an, seg, exp_ready(), exp_an(), exp_seg());
        end
        @(negedge clk);
      end
      $display("sweep r_in=%b -> twos=%b seg_digit_model=%b", order[i], twos_out, glyph(order[i][2:0]));
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    int gap;
    for (int i = 0; i < 12; i++) begin
      v = 4'($urandom_range(15, 0));
      gap = $urandom_range(2, 0);
      for (int k = 0; k < gap; k++) @(negedge clk);
      send(v);
      checks++;
      if (twos_out !== ref_twos(v) || seg !== exp_seg() || r_ready !== exp_ready()) begin
        failures++;
        $display("FAIL back_to_back r_in=%b: twos=%b seg=%b ready=%b, required %b %b %b", v, twos_out,
                 seg, r_ready, ref_twos(v), exp_seg(), exp_ready());
      end
      $display("back_to_back r_in=%b gap=%0d -> twos=%b", v, gap, twos_out);
    end
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_neg6();
    test_negzero();
    test_hold();
    test_async_reset();
    test_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
